// File: rtl/quic_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// quic_pkg : shared types and constants for the QUIC receive path
// Rev 1.0
// ----------------------------------------------------------------------------
package quic_pkg;

  localparam int QUIC_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    ABORT = 2'd3
  } quic_rx_arb_state_e;

endpackage
`default_nettype wire

// File: rtl/quic_rx_arb_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// quic_rx_arb_if : byte-source and parser handshake bundle for quic_rx_arb
// Rev 1.0
// ----------------------------------------------------------------------------
interface quic_rx_arb_if #(
  parameter int N_SRC = 4
);
  import quic_pkg::*;

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0]             src_valid;
  logic [QUIC_BYTE_W*N_SRC-1:0] src_data;
  logic [N_SRC-1:0]             src_last;
  logic [N_SRC-1:0]             src_ready;
  logic                         par_valid;
  logic [QUIC_BYTE_W-1:0]       par_data;
  logic                         par_last;
  logic                         par_ready;
  logic [IDX_W-1:0]             par_src;
  logic                         par_err;
  logic                         par_abort;

  // master is the arbiter, slave is the surrounding sources plus parser
  modport master (
    input  src_valid, src_data, src_last, par_ready, par_err,
    output src_ready, par_valid, par_data, par_last, par_src, par_abort
  );

  modport slave (
    output src_valid, src_data, src_last, par_ready, par_err,
    input  src_ready, par_valid, par_data, par_last, par_src, par_abort
  );

endinterface
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_pick : combinational round-robin finder, searches req from ptr+1 with wrap
// Rev 1.0
// ----------------------------------------------------------------------------
module rr_pick #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  function automatic logic [W-1:0] wrap_add(input logic [W-1:0] base, input int step);
    int s;
    s = int'(base) + step;
    if (s >= N) s = s - N;
    return W'(s);
  endfunction

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      if (!found && req[wrap_add(ptr, k)]) begin
        found = 1'b1;
        idx   = wrap_add(ptr, k);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/quic_rx_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// quic_rx_arb : round-robin packet arbiter sharing one QUIC header parser
// Rev 1.0
// ----------------------------------------------------------------------------
module quic_rx_arb
  import quic_pkg::*;
#(
  parameter int N_SRC   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  quic_rx_arb_if.master      bus,
  output logic               busy,
  output logic [15:0]        pkt_cnt,
  output logic [15:0]        drop_cnt
);

  localparam int          IDX_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  quic_rx_arb_state_e state, state_nxt;

  logic [IDX_W-1:0]       grant;
  logic [IDX_W-1:0]       rr_ptr;
  logic [N_SRC-1:0]       stale;
  logic [N_SRC-1:0]       stale_nxt;
  logic [15:0]            idle_ctr;
  logic                   pick_found;
  logic [IDX_W-1:0]       pick_idx;
  logic                   g_valid;
  logic                   g_last;
  logic [QUIC_BYTE_W-1:0] g_data;
  logic                   beat;
  logic                   stall;
  logic                   tmo;
  logic                   pkt_inc;
  logic                   drop_inc;
  logic [N_SRC-1:0]       ready_v;
  logic                   pv;
  logic [QUIC_BYTE_W-1:0] pd;
  logic                   pl;
  logic                   pa;

  rr_pick #(.N(N_SRC), .W(IDX_W)) u_pick (
    .req   (bus.src_valid & ~stale),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign g_valid = bus.src_valid[grant];
  assign g_last  = bus.src_last[grant];
  assign g_data  = bus.src_data[QUIC_BYTE_W*int'(grant) +: QUIC_BYTE_W];

  // In DRAIN the source is always ready, so any valid byte is a beat
  assign beat  = ((state == XFER) && g_valid && bus.par_ready) ||
                 ((state == DRAIN) && g_valid);
  assign stall = ((state == XFER) || (state == DRAIN)) && !beat;
  assign tmo   = stall && (idle_ctr == TMO_LAST);

  assign pkt_inc  = (state == XFER) && !bus.par_err && beat && g_last;
  assign drop_inc = ((state == XFER) && bus.par_err && beat && g_last) ||
                    ((state == DRAIN) && beat && g_last) ||
                    (state == ABORT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (pick_found) state_nxt = XFER;
      XFER: begin
        if (bus.par_err)         state_nxt = (beat && g_last) ? IDLE : DRAIN;
        else if (beat && g_last) state_nxt = IDLE;
        else if (tmo)            state_nxt = ABORT;
      end
      DRAIN: begin
        if (beat && g_last) state_nxt = IDLE;
        else if (tmo)       state_nxt = ABORT;
      end
      ABORT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready_v = stale;
    pv      = 1'b0;
    pd      = '0;
    pl      = 1'b0;
    pa      = 1'b0;
    case (state)
      XFER: begin
        pv             = g_valid;
        pd             = g_data;
        pl             = g_last;
        ready_v[grant] = ready_v[grant] | bus.par_ready;
      end
      DRAIN:   ready_v[grant] = 1'b1;
      ABORT:   pa = 1'b1;
      default: ;
    endcase
  end

  // A stale source leaves quarantine once its trailing last byte is swallowed
  always_comb begin
    stale_nxt = stale & ~(bus.src_valid & bus.src_last);
    if (state == ABORT) stale_nxt[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant    <= '0;
      rr_ptr   <= IDX_W'(N_SRC - 1);
      stale    <= '0;
      idle_ctr <= '0;
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if ((state == IDLE) && pick_found) begin
        grant  <= pick_idx;
        rr_ptr <= pick_idx;
      end
      stale <= stale_nxt;
      if ((state_nxt != state) || beat) idle_ctr <= '0;
      else if (stall)                   idle_ctr <= idle_ctr + 16'd1;
      if (pkt_inc && (pkt_cnt != 16'hFFFF))   pkt_cnt  <= pkt_cnt + 16'd1;
      if (drop_inc && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign bus.src_ready = ready_v;
  assign bus.par_valid = pv;
  assign bus.par_data  = pd;
  assign bus.par_last  = pl;
  assign bus.par_abort = pa;
  assign bus.par_src   = grant;
  assign busy          = (state != IDLE);

endmodule
`default_nettype wire
